rs_free_track: RTL and testbench

RS_FREE_TRACK -- requirements
Module: rs_free_track

---
 rtl/rs_pkg.sv | 17 +
 rtl/rs_free_track_if.sv | 37 +++
 rtl/rs_popcnt.sv | 20 ++
 rtl/rs_free_track.sv | 137 +++++++++++++
 tb/tb_rs_free_track.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// rs_pkg -- shared constants and types for the reservation-station free tracker.
//   RS_LOW_FREE_THRESH   : lowFree asserts while the free count is below this
//   RS_REL_DELAY_DEFAULT : default release-to-free latency in cycles
//   rs_cnt_t             : free-count type sized for the default slot count
// The default slot count comes from the `RS_BUF_COUNT macro (8 if not set).
`ifndef RS_BUF_COUNT
`define RS_BUF_COUNT 8
`endif

package rs_pkg;
  localparam int RS_BUF_COUNT         = `RS_BUF_COUNT;
  localparam int RS_LOW_FREE_THRESH   = 3;
  localparam int RS_REL_DELAY_DEFAULT = 2;
  localparam int RS_CNT_W             = $clog2(RS_BUF_COUNT + 1);

  typedef logic [RS_CNT_W-1:0] rs_cnt_t;
endpackage

// File: rtl/rs_free_track_if.sv
// rs_free_track_if -- bundle of the allocator/issue-side signals of the
// reservation-station free tracker.
//   newRsSelect0..2 : one-hot-or-zero allocations this cycle
//   release0..2     : one-hot-or-zero slots vacated this cycle
//   flush           : return every slot to free
//   bufFree         : registered free bitmap (1 = free)
//   freeCount       : registered popcount of bufFree
//   lowFree         : registered, freeCount below the low threshold
//   error           : sticky protocol-violation flag
// Handshake: there is no valid/ready pair. A nonzero select or release bit is
// the request and is always accepted in the cycle it is presented; the tracker
// never back-pressures, so the allocator must only pick slots shown free.
interface rs_free_track_if #(parameter int WIDTH = `RS_BUF_COUNT);
  logic [WIDTH-1:0]             newRsSelect0;
  logic [WIDTH-1:0]             newRsSelect1;
  logic [WIDTH-1:0]             newRsSelect2;
  logic [WIDTH-1:0]             release0;
  logic [WIDTH-1:0]             release1;
  logic [WIDTH-1:0]             release2;
  logic                         flush;
  logic [WIDTH-1:0]             bufFree;
  logic [$clog2(WIDTH+1)-1:0]   freeCount;
  logic                         lowFree;
  logic                         error;

  modport master (
    output newRsSelect0, newRsSelect1, newRsSelect2,
    output release0, release1, release2, flush,
    input  bufFree, freeCount, lowFree, error
  );

  modport slave (
    input  newRsSelect0, newRsSelect1, newRsSelect2,
    input  release0, release1, release2, flush,
    output bufFree, freeCount, lowFree, error
  );
endinterface

// File: rtl/rs_popcnt.sv
// rs_popcnt -- combinational population count.
//   bits  : input vector, WIDTH bits
//   count : number of ones in bits, $clog2(WIDTH+1) bits
module rs_popcnt
  import rs_pkg::*;
#(
  parameter int WIDTH = RS_BUF_COUNT
) (
  input  logic [WIDTH-1:0]           bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);
  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end
endmodule

// File: rtl/rs_free_track.sv
// rs_free_track -- free-slot bitmap for the reservation station.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   newRsSelect0..2     : one-hot-or-zero allocations (cleared next cycle)
//   release0..2         : one-hot-or-zero releases (free again REL_DELAY later)
//   flush               : all slots free next cycle, in-flight releases dropped
//   bufFree             : registered free bitmap, 1 = free
//   freeCount, lowFree  : registered popcount of bufFree and "fewer than 3 free"
//   error               : sticky protocol-violation flag
// Optional feature: define RS_FREE_CHECK_EN to build the protocol checker;
// without it error is tied low and no checking logic exists.
module rs_free_track
  import rs_pkg::*;
#(
  parameter int WIDTH     = `RS_BUF_COUNT,
  parameter int REL_DELAY = RS_REL_DELAY_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             newRsSelect0,
  input  logic [WIDTH-1:0]             newRsSelect1,
  input  logic [WIDTH-1:0]             newRsSelect2,
  input  logic [WIDTH-1:0]             release0,
  input  logic [WIDTH-1:0]             release1,
  input  logic [WIDTH-1:0]             release2,
  input  logic                         flush,
  output logic [WIDTH-1:0]             bufFree,
  output logic [$clog2(WIDTH+1)-1:0]   freeCount,
  output logic                         lowFree,
  output logic                         error
);
  localparam int CW = $clog2(WIDTH + 1);
  // The bufFree register itself is the final delay stage, so only
  // REL_DELAY-1 explicit stages are needed for a total latency of REL_DELAY.
  localparam int STAGES = REL_DELAY - 1;

  logic [WIDTH-1:0] alloc_mask;
  logic [WIDTH-1:0] rel_mask;
  logic [WIDTH-1:0] rel_mature;
  logic [WIDTH-1:0] buf_free_d, buf_free_q;
  logic [CW-1:0]    free_count_d, free_count_q;
  logic             low_free_d, low_free_q;
`ifdef RS_FREE_CHECK_EN
  logic [WIDTH-1:0] rel_pending;
`endif

  if (REL_DELAY > 1) begin : g_pipe
    logic [WIDTH-1:0] pipe_d [STAGES];
    logic [WIDTH-1:0] pipe_q [STAGES];

    always_comb begin
      for (int i = 0; i < STAGES; i++) pipe_d[i] = '0;
      // A flush empties the pipeline and also drops this cycle's releases.
      if (!flush) begin
        pipe_d[0] = rel_mask;
        for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
      end else begin
        for (int i = 0; i < STAGES; i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign rel_mature = pipe_q[STAGES-1];

`ifdef RS_FREE_CHECK_EN
    always_comb begin
      rel_pending = '0;
      for (int i = 0; i < STAGES; i++) rel_pending = rel_pending | pipe_q[i];
    end
`endif
  end else begin : g_no_pipe
    assign rel_mature = rel_mask;
`ifdef RS_FREE_CHECK_EN
    assign rel_pending = '0;
`endif
  end

  always_comb begin
    alloc_mask = newRsSelect0 | newRsSelect1 | newRsSelect2;
    rel_mask   = release0 | release1 | release2;
    // Alloc is applied after the matured release so it wins a same-slot race.
    if (flush) buf_free_d = '1;
    else       buf_free_d = (buf_free_q | rel_mature) & ~alloc_mask;
    low_free_d = (free_count_d < CW'(RS_LOW_FREE_THRESH));
  end

  // Counting the next-state bitmap keeps freeCount coherent with bufFree.
  rs_popcnt #(.WIDTH(WIDTH)) u_popcnt (
    .bits  (buf_free_d),
    .count (free_count_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_free_q   <= '1;
      free_count_q <= CW'(WIDTH);
      low_free_q   <= 1'b0;
    end else begin
      buf_free_q   <= buf_free_d;
      free_count_q <= free_count_d;
      low_free_q   <= low_free_d;
    end
  end

  assign bufFree   = buf_free_q;
  assign freeCount = free_count_q;
  assign lowFree   = low_free_q;

`ifdef RS_FREE_CHECK_EN
  logic error_d, error_q;
  logic viol;

  always_comb begin
    viol = (|(alloc_mask & ~buf_free_q))
         | (|(rel_mask & (buf_free_q | rel_pending)))
         | (|((newRsSelect0 & newRsSelect1) | (newRsSelect0 & newRsSelect2) |
              (newRsSelect1 & newRsSelect2)))
         | (|((release0 & release1) | (release0 & release2) | (release1 & release2)));
    // Inputs presented with flush are discarded, so they cannot violate.
    error_d = error_q | (viol & ~flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= error_d;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_rs_free_track.sv
module tb_rs_free_track;
  localparam int W  = 8;
  localparam int RD = 2;
`ifdef RS_FREE_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] mask;
    int           due;
  } rel_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rs_free_track_if #(.WIDTH(W)) bus ();

  rs_free_track #(.WIDTH(W), .REL_DELAY(RD)) dut (
    .clk          (clk),
    .rst          (rst),
    .newRsSelect0 (bus.newRsSelect0),
    .newRsSelect1 (bus.newRsSelect1),
    .newRsSelect2 (bus.newRsSelect2),
    .release0     (bus.release0),
    .release1     (bus.release1),
    .release2     (bus.release2),
    .flush        (bus.flush),
    .bufFree      (bus.bufFree),
    .freeCount    (bus.freeCount),
    .lowFree      (bus.lowFree),
    .error        (bus.error)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-slot free bits plus a list of releases with the
  // cycle in which each slot becomes free.
  logic [W-1:0] m_free;
  logic         m_err;
  int           m_cyc;
  rel_t         m_q[$];
  logic [W-1:0] exp_q[$];

  // Driver tasks
  task automatic clear_inputs();
    bus.newRsSelect0 = '0; bus.newRsSelect1 = '0; bus.newRsSelect2 = '0;
    bus.release0 = '0; bus.release1 = '0; bus.release2 = '0;
    bus.flush = 1'b0;
  endtask

  task automatic cyc(input logic [W-1:0] a0, a1, a2, r0, r1, r2, input logic fl);
    bus.newRsSelect0 = a0; bus.newRsSelect1 = a1; bus.newRsSelect2 = a2;
    bus.release0 = r0; bus.release1 = r1; bus.release2 = r2;
    bus.flush = fl;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] pick(input logic [W-1:0] avail, input int start);
    logic [W-1:0] one;
    one = 1;
    for (int i = 0; i < W; i++) begin
      if (avail[(start + i) % W]) return one << ((start + i) % W);
    end
    return '0;
  endfunction

  task automatic model_step(input logic [W-1:0] a0, a1, a2, r0, r1, r2, input logic fl);
    logic [W-1:0] mature, pend, alloc, rel;
    alloc = a0 | a1 | a2;
    rel   = r0 | r1 | r2;
    pend  = '0;
    foreach (m_q[i]) pend = pend | m_q[i].mask;
    if (CHECK_EN && !fl) begin
      if ((alloc & ~m_free) != 0) m_err = 1'b1;
      if ((rel & (m_free | pend)) != 0) m_err = 1'b1;
      if (((a0 & a1) | (a0 & a2) | (a1 & a2)) != 0) m_err = 1'b1;
      if (((r0 & r1) | (r0 & r2) | (r1 & r2)) != 0) m_err = 1'b1;
    end
    mature = '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].due == m_cyc + 1) begin
        mature = mature | m_q[i].mask;
        m_q.delete(i);
      end
    end
    if (fl) begin
      m_free = '1;
      m_q.delete();
    end else begin
      m_free = (m_free | mature) & ~alloc;
      if (rel != 0) m_q.push_back('{mask: rel, due: m_cyc + RD});
    end
    m_cyc++;
    exp_q.push_back(m_free);
  endtask

  // Tests
  task automatic test_reset();
    #1;
    total++; if (bus.bufFree !== 8'hFF) begin bad++; $display("FAIL reset_buf: got %h want ff", bus.bufFree); end
    total++; if (bus.freeCount !== 4'd8) begin bad++; $display("FAIL reset_cnt: got %0d want 8", bus.freeCount); end
    total++; if (bus.lowFree !== 1'b0) begin bad++; $display("FAIL reset_low: got %b want 0", bus.lowFree); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.error); end
    @(negedge clk);
    rst = 1'b0;
    cyc(8'h01, '0, '0, '0, '0, '0, 1'b0);
    cyc('0, '0, '0, 8'h01, '0, '0, 1'b0);
    // Mid-cycle reset with the release of slot 0 still in flight.
    #2 rst = 1'b1;
    #1;
    total++; if (bus.bufFree !== 8'hFF) begin bad++; $display("FAIL async_reset_buf: got %h want ff", bus.bufFree); end
    total++; if (bus.freeCount !== 4'd8) begin bad++; $display("FAIL async_reset_cnt: got %0d want 8", bus.freeCount); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(8'h01, '0, '0, '0, '0, '0, 1'b0);
    idle(3);
    total++; if (bus.bufFree !== 8'hFE) begin bad++; $display("FAIL reset_drops_release: got %h want fe", bus.bufFree); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_triple_alloc();
    cyc(8'h01, 8'h80, 8'h02, '0, '0, '0, 1'b0);
    total++; if (bus.bufFree !== 8'h7C) begin bad++; $display("FAIL triple_buf: got %h want 7c", bus.bufFree); end
    total++; if (bus.freeCount !== 4'd5) begin bad++; $display("FAIL triple_cnt: got %0d want 5", bus.freeCount); end
  endtask

  task automatic test_release_latency();
    idle(1);
    cyc('0, '0, '0, 8'h01, '0, '0, 1'b0);
    total++; if (bus.bufFree !== 8'h7C) begin bad++; $display("FAIL rel_early_buf: got %h want 7c", bus.bufFree); end
    total++; if (bus.freeCount !== 4'd5) begin bad++; $display("FAIL rel_early_cnt: got %0d want 5", bus.freeCount); end
    idle(1);
    total++; if (bus.bufFree !== 8'h7D) begin bad++; $display("FAIL rel_mature_buf: got %h want 7d", bus.bufFree); end
    total++; if (bus.freeCount !== 4'd6) begin bad++; $display("FAIL rel_mature_cnt: got %0d want 6", bus.freeCount); end
  endtask

  task automatic test_low_free();
    cyc(8'h04, 8'h08, 8'h10, '0, '0, '0, 1'b0);
    total++; if ({bus.freeCount, bus.lowFree} !== {4'd3, 1'b0}) begin bad++; $display("FAIL low_at3: got %0d/%b want 3/0", bus.freeCount, bus.lowFree); end
    cyc('0, 8'h20, '0, '0, '0, '0, 1'b0);
    total++; if ({bus.bufFree, bus.freeCount, bus.lowFree} !== {8'h41, 4'd2, 1'b1}) begin bad++; $display("FAIL low_at2: got %h/%0d/%b want 41/2/1", bus.bufFree, bus.freeCount, bus.lowFree); end
    cyc('0, '0, '0, '0, '0, 8'h04, 1'b0);
    total++; if (bus.lowFree !== 1'b1) begin bad++; $display("FAIL low_pending: got %b want 1", bus.lowFree); end
    idle(1);
    total++; if ({bus.bufFree, bus.freeCount, bus.lowFree} !== {8'h45, 4'd3, 1'b0}) begin bad++; $display("FAIL low_back3: got %h/%0d/%b want 45/3/0", bus.bufFree, bus.freeCount, bus.lowFree); end
  endtask

  task automatic test_flush();
    cyc('0, '0, '0, '0, 8'h08, '0, 1'b0);
    cyc(8'h10, '0, '0, 8'h20, '0, '0, 1'b1);
    total++; if ({bus.bufFree, bus.freeCount, bus.lowFree} !== {8'hFF, 4'd8, 1'b0}) begin bad++; $display("FAIL flush_next: got %h/%0d/%b want ff/8/0", bus.bufFree, bus.freeCount, bus.lowFree); end
    idle(2);
    total++; if (bus.bufFree !== 8'hFF) begin bad++; $display("FAIL flush_stale: got %h want ff", bus.bufFree); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL flush_err: got %b want 0", bus.error); end
  endtask

  task automatic test_check();
    cyc(8'h04, '0, '0, '0, '0, '0, 1'b0);
    total++; if ({bus.bufFree, bus.error} !== {8'hFB, 1'b0}) begin bad++; $display("FAIL chk_first: got %h/%b want fb/0", bus.bufFree, bus.error); end
    cyc(8'h04, '0, '0, '0, '0, '0, 1'b0);
    total++; if (bus.error !== CHECK_EN) begin bad++; $display("FAIL chk_busy_alloc: got %b want %b", bus.error, CHECK_EN); end
    idle(3);
    total++; if (bus.error !== CHECK_EN) begin bad++; $display("FAIL chk_sticky: got %b want %b", bus.error, CHECK_EN); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL chk_reset_clear: got %b want 0", bus.error); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] a[3], r[3], avail_a, avail_r, pend, exp_free;
    logic fl;
    m_free = '1; m_err = 1'b0; m_cyc = 0;
    m_q.delete(); exp_q.delete();
    exp_q.push_back(m_free);
    for (int k = 0; k < n; k++) begin
      exp_free = exp_q.pop_front();
      total++; if (bus.bufFree !== exp_free) begin bad++; $display("FAIL rnd_buf[%0d]: got %h want %h", k, bus.bufFree, exp_free); end
      total++; if (bus.freeCount !== 4'($countones(exp_free))) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", k, bus.freeCount, $countones(exp_free)); end
      total++; if (bus.lowFree !== ($countones(exp_free) < 3)) begin bad++; $display("FAIL rnd_low[%0d]: got %b", k, bus.lowFree); end
      total++; if (bus.error !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", k, bus.error, m_err); end
      pend = '0;
      foreach (m_q[i]) pend = pend | m_q[i].mask;
      avail_a = m_free;
      avail_r = ~m_free & ~pend;
      for (int p = 0; p < 3; p++) begin
        a[p] = ($urandom_range(0, 2) != 0) ? pick(avail_a, int'($urandom_range(0, W-1))) : '0;
        avail_a = avail_a & ~a[p];
        r[p] = ($urandom_range(0, 3) != 0) ? pick(avail_r, int'($urandom_range(0, W-1))) : '0;
        avail_r = avail_r & ~r[p];
      end
      fl = ($urandom_range(0, 24) == 0);
      model_step(a[0], a[1], a[2], r[0], r[1], r[2], fl);
      cyc(a[0], a[1], a[2], r[0], r[1], r[2], fl);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_triple_alloc();
    test_release_latency();
    test_low_free();
    test_flush();
    test_check();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
